// File: rtl/spi_flash_reader_pkg.sv
// Shared constants and FSM encoding for the SPI NOR flash READ (03h) sequencer.
package spi_flash_reader_pkg;

  localparam logic [7:0]  SPI_FLASH_CMD_READ = 8'h03;
  localparam int unsigned SPI_FLASH_HDR_LEN  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StA2,
    StA1,
    StA0,
    StDummy,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/spi_flash_reader_byte_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, and it never wraps below zero.
module spi_flash_reader_byte_counter #(
  parameter int unsigned Width = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/spi_flash_reader.sv
// READ (03h) burst sequencer: feeds command/address/dummy bytes to the SPI master and
// forwards the received data bytes, dropping the four header echoes.
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int unsigned LW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [23:0]   addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tx_data,
  input  logic          tx_get,
  output logic          tx_empty,
  input  logic [7:0]    rx_data,
  input  logic          rx_put,
  output logic [7:0]    data,
  output logic          valid
);

  localparam int unsigned CW = LW + 1;

  state_e        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;

  logic          accept;
  logic          tx_dec;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_zero, rx_zero;
  logic          rx_hit, rx_last, rx_is_data;

  // DONE counts as idle so a held start chains straight into the next burst.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign tx_dec = (state_q == StDummy) && tx_get;

  assign rx_hit     = busy && rx_put && !rx_zero;
  assign rx_last    = rx_hit && (rx_cnt == CW'(1));
  // Remaining count above len means the byte is one of the header echoes.
  assign rx_is_data = rx_hit && (rx_cnt <= {1'b0, len_q});

  spi_flash_reader_byte_counter #(
    .Width(CW)
  ) u_tx_cnt (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (accept),
    .load_val_i({1'b0, len}),
    .dec_i     (tx_dec),
    .count_o   (tx_cnt),
    .zero_o    (tx_zero)
  );

  spi_flash_reader_byte_counter #(
    .Width(CW)
  ) u_rx_cnt (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (accept),
    .load_val_i({1'b0, len} + CW'(SPI_FLASH_HDR_LEN)),
    .dec_i     (rx_hit),
    .count_o   (rx_cnt),
    .zero_o    (rx_zero)
  );

  always_comb begin
    state_d  = state_q;
    tx_empty = 1'b1;
    tx_data  = 8'h00;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (len == '0) ? StDone : StCmd;
      end
      StCmd: begin
        tx_empty = 1'b0;
        tx_data  = SPI_FLASH_CMD_READ;
        if (tx_get) state_d = StA2;
      end
      StA2: begin
        tx_empty = 1'b0;
        tx_data  = addr_q[23:16];
        if (tx_get) state_d = StA1;
      end
      StA1: begin
        tx_empty = 1'b0;
        tx_data  = addr_q[15:8];
        if (tx_get) state_d = StA0;
      end
      StA0: begin
        tx_empty = 1'b0;
        tx_data  = addr_q[7:0];
        if (tx_get) state_d = StDummy;
      end
      StDummy: begin
        tx_empty = 1'b0;
        if ((tx_get && (tx_cnt == CW'(1))) || tx_zero) state_d = StWait;
      end
      StWait: begin
        state_d = StWait;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        if (accept) state_d = (len == '0) ? StDone : StCmd;
      end
    endcase
    // The final echo ends the burst regardless of where the TX side is.
    if (rx_last) state_d = StDone;
  end

  always_comb begin
    addr_d  = accept ? addr : addr_q;
    len_d   = accept ? len : len_q;
    valid_d = rx_is_data;
    data_d  = rx_is_data ? rx_data : data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench: a master model drives get/put; a negedge monitor checks TX bytes, data and done.
module tb_spi_flash_reader;

  localparam int unsigned LW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, tx_empty, valid;
  logic [7:0]    tx_data, data;
  logic          tx_get = 1'b0;
  logic          rx_put = 1'b0;
  logic [7:0]    rx_data = '0;

  spi_flash_reader #(
    .LW(LW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .addr    (addr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .tx_data (tx_data),
    .tx_get  (tx_get),
    .tx_empty(tx_empty),
    .rx_data (rx_data),
    .rx_put  (rx_put),
    .data    (data),
    .valid   (valid)
  );

  always #5 clock = ~clock;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_data[$];
  logic [7:0] miso[$];
  int         exp_len[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_get = 0;
  int         n_done = 0;
  int         cur_valid = 0;
  bit         mst_en = 1'b0;
  int         mst_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the flash sees 03, A[23:16], A[15:8], A[7:0], then len dummies; the
  // first four MISO bytes are header echoes, the remaining len are the data stream.
  task automatic plan_txn(input logic [23:0] a, input int l, input bit rnd);
    logic [7:0] b;
    exp_tx.push_back(8'h03);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    for (int i = 0; i < l; i++) exp_tx.push_back(8'h00);
    exp_len.push_back(l);
    if (rnd) begin
      for (int i = 0; i < 4; i++) miso.push_back(8'($urandom));
      for (int i = 0; i < l; i++) begin
        b = 8'($urandom);
        miso.push_back(b);
        exp_data.push_back(b);
      end
    end
  endtask

  task automatic flush();
    exp_tx.delete();
    exp_data.delete();
    exp_len.delete();
    miso.delete();
    cur_valid = 0;
  endtask

  task automatic run_start(input logic [23:0] a, input int l);
    @(posedge clock); #1;
    start = 1'b1;
    addr  = a;
    len   = LW'(l);
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_tx_data", tx_data, 8'h03);
    chk("start_tx_empty", tx_empty, 0);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    if (n_done < target) fail(name);
  endtask

  task automatic wait_gets(input int target, input int budget, input string name);
    int k = 0;
    while (n_get < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    if (n_get < target) fail(name);
  endtask

  // SPI master model: one byte per (2 + mst_gap) cycles; each received byte is put
  // together with the get of the following byte, as a real shift register would.
  initial begin : master
    int         wait_cnt;
    bit         pend, got;
    logic [7:0] pend_b;
    wait_cnt = 0;
    pend     = 1'b0;
    pend_b   = '0;
    forever begin
      @(posedge clock); #1;
      tx_get = 1'b0;
      rx_put = 1'b0;
      if (!mst_en) begin
        pend     = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        got = !tx_empty;
        if (pend) begin
          rx_put  = 1'b1;
          rx_data = pend_b;
          pend    = 1'b0;
        end
        if (got) begin
          tx_get = 1'b1;
          pend   = 1'b1;
          pend_b = (miso.size() > 0) ? miso.pop_front() : 8'hEE;
        end
        if (got || rx_put) wait_cnt = 1 + mst_gap;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (tx_get && !tx_empty) begin
        n_get++;
        if (exp_tx.size() == 0) fail("tx_extra_byte");
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (valid) begin
        cur_valid++;
        if (exp_data.size() == 0) fail("unexpected_valid");
        else chk("rx_data", data, exp_data.pop_front());
      end
      if (done) begin
        n_done++;
        chk("done_not_busy", busy, 0);
        if (exp_len.size() == 0) fail("unexpected_done");
        else chk("valid_count_per_burst", cur_valid, exp_len.pop_front());
        cur_valid = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic [23:0] a, a2;
    int          l, l2, base, d0, k, gap_err;

    #1 reset_n = 1'b0;
    #11;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    mst_en  = 1'b1;

    // Directed burst with known echoes.
    mst_gap = 0;
    d0 = n_done;
    plan_txn(24'h123456, 3, 1'b0);
    miso = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h11, 8'h22, 8'h33};
    exp_data = '{8'h11, 8'h22, 8'h33};
    run_start(24'h123456, 3);
    wait_done(d0 + 1, 100, "directed_done_timeout");

    // Zero length: done at t+1, no SPI activity.
    @(posedge clock); #1;
    exp_len.push_back(0);
    start = 1'b1;
    addr  = 24'hABCDEF;
    len   = '0;
    @(posedge clock); #1;
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_tx_empty", tx_empty, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("len0_idle_busy", busy, 0);
      chk("len0_idle_tx_empty", tx_empty, 1);
    end

    // Start pulsed mid-burst must be ignored.
    mst_gap = 1;
    a = 24'($urandom);
    d0 = n_done;
    plan_txn(a, 6, 1'b1);
    base = n_get;
    run_start(a, 6);
    wait_gets(base + 3, 50, "midstart_get_timeout");
    @(posedge clock); #1;
    start = 1'b1;
    addr  = ~a;
    len   = LW'(5);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(d0 + 1, 200, "midstart_done_timeout");

    // Randomized bursts.
    for (int t = 0; t < 8; t++) begin
      mst_gap = $urandom_range(0, 2);
      a = 24'($urandom);
      l = $urandom_range(1, 20);
      d0 = n_done;
      plan_txn(a, l, 1'b1);
      run_start(a, l);
      wait_done(d0 + 1, 5 * (l + 8) + 20, "rand_done_timeout");
    end

    // Long burst with coincident get/put; TX source must never run dry.
    mst_gap = 0;
    a = 24'($urandom);
    d0 = n_done;
    plan_txn(a, 300, 1'b1);
    base = n_get;
    run_start(a, 300);
    k = 0;
    gap_err = 0;
    while (n_get < base + 304 && k < 2000) begin
      if (tx_empty) gap_err++;
      @(posedge clock); #2;
      k++;
    end
    chk("len300_no_tx_gap", gap_err, 0);
    chk("len300_all_tx", n_get - base, 304);
    wait_done(d0 + 1, 100, "len300_done_timeout");

    // Reset while presenting A1.
    mst_gap = 1;
    a = 24'($urandom);
    plan_txn(a, 5, 1'b1);
    base = n_get;
    run_start(a, 5);
    wait_gets(base + 2, 50, "a1_get_timeout");
    #3;
    chk("a1_tx_data", tx_data, a[15:8]);
    reset_n = 1'b0;
    mst_en  = 1'b0;
    flush();
    d0 = n_done;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_empty", tx_empty, 1);
    chk("midrst_done", done, 0);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b1;
    mst_en  = 1'b1;
    repeat (3) @(posedge clock);
    chk("midrst_no_done", n_done, d0);

    // Clean burst after reset.
    a = 24'($urandom);
    d0 = n_done;
    plan_txn(a, 4, 1'b1);
    run_start(a, 4);
    wait_done(d0 + 1, 100, "postrst_done_timeout");

    // Start held through done chains a second burst.
    mst_gap = 0;
    a  = 24'($urandom);
    a2 = 24'($urandom);
    l  = $urandom_range(1, 6);
    l2 = $urandom_range(1, 6);
    d0 = n_done;
    plan_txn(a, l, 1'b1);
    run_start(a, l);
    plan_txn(a2, l2, 1'b1);
    start = 1'b1;
    addr  = a2;
    len   = LW'(l2);
    wait_done(d0 + 1, 100, "b2b_first_done_timeout");
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_tx_data", tx_data, 8'h03);
    wait_done(d0 + 2, 100, "b2b_second_done_timeout");

    repeat (20) @(posedge clock);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("data_queue_drained", exp_data.size(), 0);
    chk("done_queue_drained", exp_len.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Command sequencer for an SPI NOR flash "READ (03h)" burst, sitting directly upstream and downstream of the SPI master. It feeds the master's byte source: command, 24-bit address, then dummy bytes. It consumes the master's received bytes, drops the four header echoes and forwards the data bytes as a pulsed stream. Chip select is framed by the master from its `empty` input, so the block keeps the byte source non-empty for the whole transaction without gaps.

## Interface
- `LW`, 16: width of the byte-length field; maximum burst is 2^LW − 1 bytes.
- `clock` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only when idle.
- `addr` in 24: flash byte address; captured on accepted `start`.
- `len` in LW: number of data bytes; captured on accepted `start`.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `tx_data` out 8: byte presented to the SPI master `in`.
- `tx_get` in 1: master `get`; the master consumed `tx_data` this cycle.
- `tx_empty` out 1: drives master `empty`; 0 while bytes remain to send.
- `rx_data` in 8: master `out`.
- `rx_put` in 1: master `put`; `rx_data` is valid this cycle.
- `data` out 8: received flash byte.
- `valid` out 1: one-cycle pulse qualifying `data`. There is no backpressure.

## Operation
- Reset values: `busy`=0, `done`=0, `tx_empty`=1, `tx_data`=8'h00, `data`=8'h00, `valid`=0, FSM=IDLE, both counters 0.
- Total transfer length `N = len + 4` bytes. Counters are LW+1 bits wide, so no overflow at the maximum `len`.
- TX FSM states:
  - IDLE: on `start`, capture `addr` and `len`, then go to CMD. If `len`=0, go to DONE instead, with no SPI activity.
  - CMD: `tx_data`=8'h03.
  - A2: `tx_data`=addr[23:16].
  - A1: `tx_data`=addr[15:8].
  - A0: `tx_data`=addr[7:0].
  - DUMMY: `tx_data`=8'h00, repeated `len` times.
  - WAIT: `tx_empty`=1; wait until the RX count reaches N.
  - DONE: single cycle, then IDLE.
- Each `tx_get` advances the FSM by one byte: CMD→A2→A1→A0→DUMMY. DUMMY decrements the TX remaining count; on its last `tx_get` the FSM goes to WAIT.
- `tx_empty` is 0 in CMD, A2, A1, A0 and DUMMY, and 1 otherwise. `tx_data` is combinational from state and address. `tx_get` is ignored while `tx_empty`=1.
- RX path:
  - `rx_put` increments the RX count while `busy`; it is ignored while idle.
  - Counts 1–4 are header echoes and are discarded.
  - Counts 5..N register `rx_data`→`data` and pulse `valid` on the next cycle.
- `busy` is 1 in every state except IDLE and DONE.
- `start` while busy is ignored, with no capture.
- `tx_get` and `rx_put` in the same cycle are both honoured; the counters are independent.
- Reset asserted mid-transaction returns the block to IDLE immediately. `tx_empty` rises, so the master releases chip select; the partial burst is lost and no `done` is issued.

## Timing
- `start` sampled at edge t → `busy`=1, `tx_empty`=0 and `tx_data`=8'h03 from t+1.
- The next `tx_data` is valid in the cycle after each `tx_get`. The master's byte period is ≥ 2 `step`s, so no gap appears.
- `data`/`valid` latency is 1 cycle after `rx_put`.
- The final `valid`, `done`=1 and `busy`=0 all occur in the same cycle: one cycle after the N-th `rx_put`.
- With `len`=0: `done` pulses at t+1 and `busy` stays 0.
- Back-to-back: `start` may be accepted in the same cycle `done` is high (FSM in DONE counts as idle for acceptance).

## Structure
- Shared package: `SPI_FLASH_CMD_READ` = 8'h03, `SPI_FLASH_HDR_LEN` = 4, and the FSM state encoding.
- One natural sub-module: `byte_counter` (loadable down-counter with zero flag), instantiated twice: TX remaining and RX remaining.
- The top level holds the FSM, the address register and the output register.

## Test plan
- `addr`=24'h123456, `len`=3, with a master model echoing MISO 8'hA0,8'hA1,8'hA2,8'hA3,8'h11,8'h22,8'h33 → `tx_data` sequence 03,12,34,56,00,00,00; `valid` pulses carry 11,22,33; `done` occurs with the third `valid`.
- `len`=0 → `done` at t+1, `busy` never 1, `tx_empty` stays 1, no `valid`.
- `start` pulsed mid-burst with a different `addr` → ignored; TX bytes and output unchanged.
- `tx_get` and `rx_put` coincident every byte (the master's normal case), `len`=300 → exactly 300 `valid` pulses, and `tx_empty` is never 1 between CMD and the last dummy byte.
- `reset_n` low during A1 → `tx_empty`=1, `busy`=0 and FSM IDLE immediately; no `done`; a new `start` after release runs a clean burst.
- `start` held high through `done` → the second transaction begins the cycle after DONE with `tx_data`=03.
